// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential restoring divider for the 8-bit lab float format
//
// Divides a_in by b_in. Both are {S, E[2:0], M[3:0]} with bias 3 and a hidden 1.
// The outputs are the un-rounded result fields consumed by the shared round/pack stage.
// The divider produces one quotient bit per cycle over 8 cycles.
// The result fields are registered and held until the consumer accepts them.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operands valid
//   in_ready   out  1  operands can be accepted (IDLE only, low during reset)
//   a_in       in   8  dividend
//   b_in       in   8  divisor
//   out_valid  out  1  result fields valid (DONE)
//   out_ready  in   1  consumer accepts result
//   Sq         out  1  quotient sign
//   NormE      out  5  normalized biased exponent, two's complement
//   NormM      out  4  normalized mantissa, hidden 1 dropped
//   GRS        out  1  round-to-nearest-even increment request
//   ovf        out  1  NormE > 7
//   unf        out  1  NormE < 0

module fp_div_seq #(
  parameter int BIAS  = 3,
  parameter int QBITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       Sq,
  output logic [4:0] NormE,
  output logic [3:0] NormM,
  output logic       GRS,
  output logic       ovf,
  output logic       unf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [5:0] r_q;     // partial remainder, holds {1,Ma} at start
  logic [4:0] y_q;     // divisor {1,Mb}
  logic [7:0] q_q;     // quotient bits, MSB first
  logic [4:0] e0_q;    // Ea - Eb + BIAS, two's complement
  logic [2:0] cnt_q;

  logic       accept;
  logic       last_step;

  // One restoring step
  logic       ge;
  logic [5:0] r_diff;
  logic [5:0] r_sel;
  logic [5:0] r_nxt;
  logic [7:0] q_nxt;

  // Normalization of the final quotient
  logic [3:0] norm_m_nxt;
  logic [4:0] norm_e_nxt;
  logic       g_bit;
  logic       s_bit;
  logic       grs_nxt;

  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == DIV) && (cnt_q == 3'(QBITS - 1));

  assign ge     = (r_q >= {1'b0, y_q});
  assign r_diff = r_q - {1'b0, y_q};
  assign r_sel  = ge ? r_diff : r_q;
  // r_sel is always below Y (< 32), so the shift never loses a set bit.
  assign r_nxt  = r_sel << 1;
  assign q_nxt  = {q_q[6:0], ge};

  // Normalization is computed from the step that is about to complete, so that the
  // result registers load on the same edge that leaves DIV.
  always_comb begin
    norm_m_nxt = 4'd0;
    norm_e_nxt = e0_q;
    g_bit      = 1'b0;
    s_bit      = 1'b0;
    if (q_nxt[7]) begin
      norm_m_nxt = q_nxt[6:3];
      g_bit      = q_nxt[2];
      s_bit      = q_nxt[1] | q_nxt[0] | (r_nxt != 6'd0);
      norm_e_nxt = e0_q;
    end else begin
      // The quotient lies in (0.5,1). Shift left by one and take one off the exponent.
      norm_m_nxt = q_nxt[5:2];
      g_bit      = q_nxt[1];
      s_bit      = q_nxt[0] | (r_nxt != 6'd0);
      norm_e_nxt = e0_q - 5'd1;
    end
    grs_nxt = g_bit & (s_bit | norm_m_nxt[0]);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DIV;
      DIV:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. in_ready is gated by rst_n so that it reads low during reset even
  // though the state register already sits in IDLE.
  always_comb begin
    in_ready  = (state_q == IDLE) && rst_n;
    out_valid = (state_q == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= 6'd0;
      y_q   <= 5'd0;
      q_q   <= 8'd0;
      e0_q  <= 5'd0;
      cnt_q <= 3'd0;
      Sq    <= 1'b0;
      NormE <= 5'd0;
      NormM <= 4'd0;
      GRS   <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (accept) begin
        Sq    <= a_in[7] ^ b_in[7];
        r_q   <= {2'b01, a_in[3:0]};
        y_q   <= {1'b1, b_in[3:0]};
        q_q   <= 8'd0;
        e0_q  <= {2'b00, a_in[6:4]} - {2'b00, b_in[6:4]} + 5'(BIAS);
        cnt_q <= 3'd0;
      end else if (state_q == DIV) begin
        r_q   <= r_nxt;
        q_q   <= q_nxt;
        cnt_q <= cnt_q + 3'd1;
        if (last_step) begin
          NormE <= norm_e_nxt;
          NormM <= norm_m_nxt;
          GRS   <= grs_nxt;
          ovf   <= ($signed(norm_e_nxt) > 5'sd7);
          unf   <= norm_e_nxt[4];
        end
      end
    end
  end

endmodule
